// File: rtl/counter_frame_pkg.sv
// Shared definitions for the counter snapshot framer.
// Contents:
//   TAG_*   3-bit beat tags placed in frame_data[7:5]
//   state_e framer FSM states
//   nchunk  number of 5-bit payload chunks needed for a w-bit snapshot
package counter_frame_pkg;

    localparam logic [2:0] TAG_HDR   = 3'b011;
    localparam logic [2:0] TAG_FIRST = 3'b010;
    localparam logic [2:0] TAG_MID   = 3'b001;
    localparam logic [2:0] TAG_LAST  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_e;

    function automatic int unsigned nchunk(input int unsigned w);
        return (w + 4) / 5;
    endfunction

endpackage

// File: rtl/frame_counter_core.sv
// Up/down counter with synchronous load and enable, plus a registered wrap flag.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   en, up_down         count enable and direction (1 = up)
//   load, load_val      load has priority over en and never raises wrap
//   count               current counter value
//   wrap                high in the same cycle count shows the wrapped value
module frame_counter_core #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               up_down,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] count,
    output logic               wrap
);

    logic [COUNT_W-1:0] count_d, count_q;
    logic               wrap_d, wrap_q;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up_down) begin
                count_d = count_q + COUNT_W'(1);
                wrap_d  = (count_q == {COUNT_W{1'b1}});
            end else begin
                count_d = count_q - COUNT_W'(1);
                wrap_d  = (count_q == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/counter_frame_tx.sv
// Counter with snapshot capture and tagged byte-frame transmitter.
// A snapshot (on snap_req, or on wrap when AUTO_SNAP is set) is sent as a header
// byte {TAG_HDR, seq} followed by NCHUNK data bytes, MSB chunk first.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   en, up_down, load,
//   load_val                  counter controls (see frame_counter_core)
//   snap_req                  request a snapshot frame
//   count, wrap               counter value and one-cycle wrap pulse
//   frame_data, frame_valid,
//   frame_ready               valid/ready byte stream {tag[2:0], payload[4:0]}
//   busy                      a frame is in progress
//   snap_drop                 one-cycle pulse: trigger arrived while busy and was discarded
module counter_frame_tx
    import counter_frame_pkg::*;
#(
    parameter int unsigned COUNT_W   = 16,
    parameter int unsigned AUTO_SNAP = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               up_down,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               snap_req,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic [7:0]         frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               busy,
    output logic               snap_drop
);

    localparam int unsigned NCHUNK = nchunk(COUNT_W);
    localparam int unsigned SNAP_W = NCHUNK * 5;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    frame_counter_core #(
        .COUNT_W (COUNT_W)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap)
    );

    state_e             state_d, state_q;
    logic [SNAP_W-1:0]  snap_d, snap_q;
    logic [4:0]         seq_d, seq_q;
    logic [IDX_W-1:0]   idx_d, idx_q;
    logic [7:0]         data_d, data_q;
    logic               valid_d, valid_q;
    logic               drop_d, drop_q;
    logic               trig, accept, last_idx;

    // Data beat for chunk idx of the zero-padded snapshot, chunk 0 being the MSBs.
    function automatic logic [7:0] data_beat(input logic [SNAP_W-1:0] snap,
                                             input logic [IDX_W-1:0]  idx);
        logic [SNAP_W-1:0] sh;
        logic [2:0]        tag;
        sh = snap >> (5 * (NCHUNK - 1 - 32'(idx)));
        if (32'(idx) == NCHUNK - 1) begin
            tag = TAG_LAST;
        end else if (idx == '0) begin
            tag = TAG_FIRST;
        end else begin
            tag = TAG_MID;
        end
        return {tag, sh[4:0]};
    endfunction

    assign trig     = snap_req | ((AUTO_SNAP != 0) & wrap);
    assign accept   = valid_q & frame_ready;
    assign last_idx = (32'(idx_q) == NCHUNK - 1);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = trig && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    // count is the registered value, so a wrap trigger captures the wrapped value
                    snap_d  = SNAP_W'(count);
                    state_d = HDR;
                    valid_d = 1'b1;
                    data_d  = {TAG_HDR, seq_q};
                end
            end
            HDR: begin
                if (accept) begin
                    state_d = DATA;
                    idx_d   = '0;
                    data_d  = data_beat(snap_q, '0);
                end
            end
            DATA: begin
                if (accept) begin
                    if (last_idx) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        seq_d   = seq_q + 5'd1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = data_beat(snap_q, idx_q + IDX_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign busy        = (state_q != IDLE);
    assign snap_drop   = drop_q;

endmodule

// File: tb/tb_counter_frame_tx.sv
// Directed table-driven bench for counter_frame_tx (COUNT_W=16, AUTO_SNAP=1).
module tb_counter_frame_tx;

    logic        clock;
    logic        reset;
    logic        en;
    logic        up_down;
    logic        load;
    logic [15:0] load_val;
    logic        snap_req;
    logic [15:0] count;
    logic        wrap;
    logic [7:0]  frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic        snap_drop;

    counter_frame_tx #(
        .COUNT_W   (16),
        .AUTO_SNAP (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .up_down     (up_down),
        .load        (load),
        .load_val    (load_val),
        .snap_req    (snap_req),
        .count       (count),
        .wrap        (wrap),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .snap_drop   (snap_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        up_down;
        logic        load;
        logic [15:0] load_val;
        logic        snap_req;
        logic        ready;
        logic [15:0] e_count;
        logic        e_wrap;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic e, input logic ud, input logic ld,
                                input logic [15:0] lv, input logic sr, input logic rdy,
                                input logic [15:0] ec, input logic ew, input logic ev,
                                input logic [7:0] ed, input logic edr);
        vec_t v;
        v.en = e; v.up_down = ud; v.load = ld; v.load_val = lv; v.snap_req = sr;
        v.ready = rdy; v.e_count = ec; v.e_wrap = ew; v.e_valid = ev; v.e_data = ed;
        v.e_drop = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic [7:0] exp);
        chk({name, " valid"}, 32'(frame_valid), 32'd1);
        chk({name, " data"}, 32'(frame_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] tail [4];
        tail[0] = 8'h40; tail[1] = 8'h20; tail[2] = 8'h20; tail[3] = 8'h80;

        //            en ud ld val       sr rdy  count    wr vl data   drop
        // 1: count up five times
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0003, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0004, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0005, 0, 0, 8'h00, 0));
        // 2: load 0x1234, snapshot frame with seq 0
        vecs.push_back(mk(0, 1, 1, 16'h1234, 0, 1, 16'h1234, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h1234, 0, 1, 8'h60, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h40, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h24, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h31, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h94, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 0, 8'h00, 0));
        // 3: up-wrap triggers an automatic frame of the wrapped value, seq 1
        vecs.push_back(mk(0, 1, 1, 16'hFFFE, 0, 1, 16'hFFFE, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 8'h61, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 8'h40, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 8'h20, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 8'h20, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 8'h80, 0));
        // last beat accepted while a new load happens
        vecs.push_back(mk(0, 1, 1, 16'h1234, 0, 1, 16'h1234, 0, 0, 8'h00, 0));
        // 4: stall four cycles on 0x24, a snap_req during the stall is dropped
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h1234, 0, 1, 8'h62, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h40, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h24, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h1234, 0, 1, 8'h24, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h1234, 0, 1, 8'h24, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h1234, 0, 1, 8'h24, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h1234, 0, 1, 8'h24, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h31, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1, 8'h94, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 0, 8'h00, 0));
        // 5: load beats en; down-wrap 0 -> 0xFFFF; auto frame of 0xFFFF, seq 3
        vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 1, 16'h0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 1, 8'h63, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 1, 8'h41, 0));

        // Reset state
        reset = 1'b1; en = 0; up_down = 1; load = 0; load_val = '0; snap_req = 0;
        frame_ready = 1;
        #12;
        chk("reset count", 32'(count), 32'd0);
        chk("reset wrap", 32'(wrap), 32'd0);
        chk("reset valid", 32'(frame_valid), 32'd0);
        chk("reset data", 32'(frame_data), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset drop", 32'(snap_drop), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            en = vecs[i].en; up_down = vecs[i].up_down; load = vecs[i].load;
            load_val = vecs[i].load_val; snap_req = vecs[i].snap_req;
            frame_ready = vecs[i].ready;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
            chk($sformatf("v%0d valid", i), 32'(frame_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d drop", i), 32'(snap_drop), 32'(vecs[i].e_drop));
            if (vecs[i].e_valid)
                chk($sformatf("v%0d data", i), 32'(frame_data), 32'(vecs[i].e_data));
        end

        // 6: asynchronous reset in the middle of a DATA beat
        #2;
        reset = 1'b1;
        #1;
        chk("mid reset valid", 32'(frame_valid), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset count", 32'(count), 32'd0);
        chk("mid reset data", 32'(frame_data), 32'd0);
        @(negedge clock);
        reset = 1'b0; en = 0; load = 0; snap_req = 1; frame_ready = 1;
        @(posedge clock);
        #1;
        chk_beat("post reset hdr", 8'h60);
        @(negedge clock);
        snap_req = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            chk_beat($sformatf("post reset beat%0d", k), tail[k]);
        end
        @(posedge clock);
        #1;
        chk("post reset idle", 32'(frame_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
